// File: rtl/audio_pwm_output.sv
// audio_pwm_output: double-buffered PWM audio output stage driving an external RC filter.
// Latency: pwm_out is registered, 1 clk after counter/active state; a new sample becomes active at the next period boundary.
// Backpressure: din_ready is low while the holding register is full and rises again at the next period boundary.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   enable          run the PWM; low holds the counters at 0 and mutes the output
//   din/din_valid/din_ready  sample handshake into the holding register
//   pwm_out         1-bit PWM output
//   period_start    1-cycle pulse aligned with pwm_cnt==0 of each new period
//   underrun        1-cycle pulse when a period began with no fresh sample
// Optional (macro UNDERRUN_CNT_EN):
//   underrun_clr    synchronous clear of the underrun counter
//   underrun_count  saturating 16-bit count of underrun pulses
module audio_pwm_output #(
  parameter int DATA_BITS = 12,
  parameter int CLK_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 pwm_out,
  output logic                 period_start,
  output logic                 underrun
`ifdef UNDERRUN_CNT_EN
  ,
  input  logic                 underrun_clr,
  output logic [15:0]          underrun_count
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [DATA_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DATA_BITS-1:0] active_q, active_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 pwm_out_q, pwm_out_d;
  logic                 period_start_q, period_start_d;
  logic                 underrun_q, underrun_d;
  logic                 step;
  logic                 boundary;
  logic                 xfer;

  always_comb begin
    step     = enable && (div_cnt_q == DIV_LAST);
    // Boundary is the edge on which pwm_cnt wraps back to 0.
    boundary = step && (pwm_cnt_q == '1);
    xfer     = din_valid && !hold_full_q;

    div_cnt_d = div_cnt_q;
    if (!enable) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    pwm_cnt_d = pwm_cnt_q;
    if (!enable) begin
      pwm_cnt_d = '0;
    end else if (step) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    active_d    = active_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (boundary && hold_full_q) begin
      active_d    = hold_q;
      hold_full_d = 1'b0;
    end
    // A transfer only happens while hold is empty, so it never collides with
    // the hold->active move above; a transfer on the boundary edge itself
    // lands in hold and waits for the following boundary.
    if (xfer) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    pwm_out_d      = enable && (pwm_cnt_q < active_q);
    period_start_d = boundary;
    underrun_d     = boundary && !hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      active_q       <= '0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      active_q       <= active_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign din_ready    = !hold_full_q;
  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;

`ifdef UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Counts on the same event that sets the underrun pulse, so the count and
  // the pulse become visible in the same cycle. Clear wins over increment.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_clr) begin
      ucnt_d = '0;
    end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_audio_pwm_output.sv
module tb_audio_pwm_output;

  localparam int DB = 4;
  localparam int CD = 2;
  localparam int PERIOD_CLKS = CD * (1 << DB);

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [DB-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          pwm_out;
  logic          period_start;
  logic          underrun;
`ifdef UNDERRUN_CNT_EN
  logic          underrun_clr;
  logic [15:0]   underrun_count;
`endif

  audio_pwm_output #(.DATA_BITS(DB), .CLK_DIV(CD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun)
`ifdef UNDERRUN_CNT_EN
    ,
    .underrun_clr   (underrun_clr),
    .underrun_count (underrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int   duty;
    logic ur;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Per-period monitor: the window for a period runs from the cycle after its
  // period_start through the next period_start cycle (pwm_out lags by 1 clk).
  logic mon_abort;
  logic mon_in_period = 1'b0;
  int   mon_hi = 0;
  int   mon_len = 0;
  logic mon_ur = 1'b0;

  task automatic finalize(input int hi, input int len, input logic ur);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_period", 32'(hi), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("period_duty", 32'(hi), 32'(e.duty));
      chk("period_underrun", {31'b0, ur}, {31'b0, e.ur});
      chk("period_len", 32'(len), 32'(PERIOD_CLKS));
    end
  endtask

  always @(posedge clk) begin
    mon_abort = !rst_n || !enable;
    #1;
    if (mon_abort) begin
      mon_in_period = 1'b0;
    end else if (period_start === 1'b1) begin
      if (mon_in_period) finalize(mon_hi + int'(pwm_out), mon_len + 1, mon_ur);
      mon_in_period = 1'b1;
      mon_hi = 0;
      mon_len = 0;
      mon_ur = underrun;
    end else if (mon_in_period) begin
      mon_hi += int'(pwm_out);
      mon_len++;
    end
  end

  task automatic push_exp(input int duty, input logic ur);
    exp_t e;
    e.duty = duty;
    e.ur = ur;
    exp_q.push_back(e);
  endtask

  task automatic wait_ps(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 200);
    if (period_start !== 1'b1) chk({tag, "_timeout"}, {31'b0, period_start}, 32'd1);
  endtask

  task automatic push_sample(input logic [DB-1:0] v, output int waited);
    din = v;
    din_valid = 1'b1;
    waited = 0;
    while (din_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (din_ready !== 1'b1) chk("push_timeout", {31'b0, din_ready}, 32'd1);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    int n;
    int w;
    int pulses;
    rst_n = 1'b0;
    enable = 1'b0;
    din = '0;
    din_valid = 1'b0;
`ifdef UNDERRUN_CNT_EN
    underrun_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_pwm_out", {31'b0, pwm_out}, 32'd0);
    chk("rst_period_start", {31'b0, period_start}, 32'd0);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
    chk("rst_din_ready", {31'b0, din_ready}, 32'd1);
`ifdef UNDERRUN_CNT_EN
    chk("rst_ucnt", {16'b0, underrun_count}, 32'd0);
`endif
    rst_n = 1'b1;

    // Sample loaded while idle, then enable: first boundary after a full period.
    push_sample(4'd4, w);
    chk("idle_hold_full", {31'b0, din_ready}, 32'd0);
    push_exp(8, 1'b0);
    enable = 1'b1;
    wait_ps("b1", n);
    chk("b1_dist", 32'(n), 32'd32);
    chk("b1_underrun", {31'b0, underrun}, 32'd0);
    chk("b1_din_ready", {31'b0, din_ready}, 32'd1);

    // No new samples: last sample repeats and underrun flags each boundary.
    push_exp(8, 1'b1);
    push_exp(8, 1'b1);
    wait_ps("b2", n);
    chk("b2_dist", 32'(n), 32'd32);
    wait_ps("b3", n);
    chk("b3_underrun", {31'b0, underrun}, 32'd1);

    // 0 then 15 on consecutive periods; second push is back-pressured.
    push_exp(0, 1'b0);
    push_exp(30, 1'b0);
    push_sample(4'd0, w);
    chk("hold_full_after_push", {31'b0, din_ready}, 32'd0);
    push_sample(4'd15, w);
    chk("backpressure_wait", 32'(w), 32'd31);
    wait_ps("b5", n);
    chk("b5_dist", 32'(n), 32'd31);
    chk("b5_din_ready", {31'b0, din_ready}, 32'd1);

    // Transfer on the exact boundary clock while empty.
    push_exp(30, 1'b1);
    push_exp(18, 1'b0);
    repeat (31) @(negedge clk);
    din = 4'd9;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("b6_period_start", {31'b0, period_start}, 32'd1);
    chk("b6_underrun", {31'b0, underrun}, 32'd1);
    chk("b6_din_ready", {31'b0, din_ready}, 32'd0);
    repeat (31) @(negedge clk);
    chk("pre_b7_din_ready", {31'b0, din_ready}, 32'd0);
    @(negedge clk);
    chk("b7_period_start", {31'b0, period_start}, 32'd1);
    chk("b7_underrun", {31'b0, underrun}, 32'd0);
    chk("b7_din_ready", {31'b0, din_ready}, 32'd1);
    wait_ps("b8", n);
    chk("b8_dist", 32'(n), 32'd32);

    // Mid-period reset with a sample held: period aborted, sample discarded.
    push_sample(4'd5, w);
    chk("pre_rst_hold_full", {31'b0, din_ready}, 32'd0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_pwm_out", {31'b0, pwm_out}, 32'd0);
    chk("mid_rst_din_ready", {31'b0, din_ready}, 32'd1);
    chk("mid_rst_period_start", {31'b0, period_start}, 32'd0);
    chk("mid_rst_pwm_cnt", 32'(dut.pwm_cnt_q), 32'd0);
    push_exp(0, 1'b1);
    push_exp(0, 1'b1);
    wait_ps("r1", n);
    chk("r1_dist", 32'(n), 32'd32);
    chk("r1_underrun", {31'b0, underrun}, 32'd1);
    wait_ps("r2", n);
    wait_ps("r3", n);
    chk("r3_underrun", {31'b0, underrun}, 32'd1);
`ifdef UNDERRUN_CNT_EN
    chk("ucnt_three", {16'b0, underrun_count}, 32'd3);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ucnt_cleared", {16'b0, underrun_count}, 32'd0);
`endif

    // Disabled: no pulses, output muted.
    enable = 1'b0;
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (period_start === 1'b1 || underrun === 1'b1 || pwm_out === 1'b1) pulses++;
    end
    chk("disabled_quiet", 32'(pulses), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
